// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

  // Arbiter control states: choose a grant, hold a transaction, pulse ready
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

  // Which requester owns the memory port
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  // No byte enables set means the data request is a load
  localparam logic [3:0]  DWE_READ         = 4'b0000;
  localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - clear/enable wait counter that flags a hung memory
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Expire fires during the last allowed wait cycle so the owner can leave BUSY
  // on the very edge that would otherwise start one cycle too many.
  assign expire_o = en_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Next count: clear wins, otherwise count enabled cycles up to the limit
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a single-ported unified memory
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          STARVE_LIMIT   = 4,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] TIMEOUT_DATA   = TIMEOUT_DATA_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_rdy,
  input  logic        d_req,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_rdy,
  output logic        m_req,
  output logic [3:0]  m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        timeout_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_e  state_q, state_d;
  logic        m_req_q, m_req_d;
  logic [3:0]  m_we_q, m_we_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_rdy_q, if_rdy_d;
  logic        d_rdy_q, d_rdy_d;
  logic        err_q, err_d;
  logic [SW-1:0] starve_q, starve_d;

  logic        busy;
  logic        d_wins;
  owner_e      win;
  owner_e      busy_owner;
  logic [31:0] rd_word;
  logic        tmr_clr;
  logic        tmr_en;
  logic        tmr_expire;

  assign busy       = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign busy_owner = (state_q == BUSY_D) ? OWN_D : OWN_IF;
  // Data wins unless fetch has already been passed over STARVE_LIMIT times
  assign d_wins     = d_req && (!if_req || (starve_q < SW'(STARVE_LIMIT)));
  assign win        = d_wins ? OWN_D : OWN_IF;
  // An ack arriving with the expiry takes precedence, so it also stops the count
  assign tmr_en     = busy && !m_ack;
  assign rd_word    = m_ack ? m_rdata : TIMEOUT_DATA;

  mem_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expire_o (tmr_expire)
  );

  // Next state: grant in IDLE, complete on ack or expiry, pulse ready in DONE
  always_comb begin
    state_d    = state_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_rdy_d   = 1'b0;
    d_rdy_d    = 1'b0;
    err_d      = err_q;
    starve_d   = starve_q;
    tmr_clr    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (d_req || if_req) begin
          m_req_d = 1'b1;
          tmr_clr = 1'b1;
          if (win == OWN_D) begin
            state_d   = BUSY_D;
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            starve_d  = if_req ? starve_q + 1'b1 : '0;
          end else begin
            state_d   = BUSY_I;
            m_we_d    = DWE_READ;
            m_addr_d  = if_addr;
            m_wdata_d = '0;
            starve_d  = '0;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        if (m_ack || tmr_expire) begin
          m_req_d = 1'b0;
          state_d = DONE;
          if (!m_ack) begin
            err_d = 1'b1;
          end
          if (busy_owner == OWN_D) begin
            d_rdy_d = 1'b1;
            if (m_we_q == DWE_READ) begin
              d_rdata_d = rd_word;
            end
          end else begin
            if_rdy_d   = 1'b1;
            if_rdata_d = rd_word;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      m_req_q    <= 1'b0;
      m_we_q     <= '0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_rdy_q   <= 1'b0;
      d_rdy_q    <= 1'b0;
      err_q      <= 1'b0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_rdy_q   <= if_rdy_d;
      d_rdy_q    <= d_rdy_d;
      err_q      <= err_d;
      starve_q   <= starve_d;
    end
  end

  assign m_req       = m_req_q;
  assign m_we        = m_we_q;
  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign if_rdy      = if_rdy_q;
  assign d_rdy       = d_rdy_q;
  assign timeout_err = err_q;
  assign stall_if    = if_req & ~if_rdy_q;
  assign stall_mem   = d_req & ~d_rdy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized and directed bench with a transaction-level model
module tb_mem_port_arbiter;

  localparam int          STARVE_LIMIT   = 4;
  localparam int          TIMEOUT_CYCLES = 64;
  localparam logic [31:0] TO_DATA        = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_rdy;
  logic        d_req;
  logic [3:0]  d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_rdy;
  logic        m_req;
  logic [3:0]  m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;
  logic        stall_if;
  logic        stall_mem;
  logic        timeout_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .STARVE_LIMIT   (STARVE_LIMIT),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_DATA   (TO_DATA)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_rdy      (if_rdy),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_rdy       (d_rdy),
    .m_req       (m_req),
    .m_we        (m_we),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_rdata     (m_rdata),
    .m_ack       (m_ack),
    .stall_if    (stall_if),
    .stall_mem   (stall_mem),
    .timeout_err (timeout_err)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // transaction-level model of the arbiter
  bit          tx_active;
  bit          tx_d;
  logic [3:0]  tx_we;
  logic [31:0] tx_addr;
  logic [31:0] tx_wdata;
  int          tx_start;
  int          idle_at;
  int          starve_m;
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_d_rdata;
  bit          exp_err;

  // memory responder
  logic [31:0] mem [64];
  int          mem_wait;
  int          mem_lat;
  int          lat_cfg;
  bit          spurious_en;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0b expected %0b", name, cyc, act, exp);
  endtask

  // Predict this cycle from the inputs present at the edge that started it,
  // then compare every DUT output against the prediction.
  task automatic model_step();
    bit exp_ifr;
    bit exp_dr;
    logic [31:0] rd;
    exp_ifr = 1'b0;
    exp_dr  = 1'b0;
    if (!rst_n) begin
      tx_active    = 1'b0;
      starve_m     = 0;
      exp_if_rdata = '0;
      exp_d_rdata  = '0;
      exp_err      = 1'b0;
      idle_at      = cyc;
    end else if (tx_active) begin
      if (m_ack || (cyc - tx_start == TIMEOUT_CYCLES)) begin
        rd = m_ack ? m_rdata : TO_DATA;
        if (!m_ack) exp_err = 1'b1;
        if (tx_we == 4'b0000) begin
          if (tx_d) exp_d_rdata = rd;
          else      exp_if_rdata = rd;
        end
        if (tx_d) exp_dr = 1'b1;
        else      exp_ifr = 1'b1;
        tx_active = 1'b0;
        idle_at   = cyc + 1;
      end
    end else if ((cyc - 1 >= idle_at) && (if_req || d_req)) begin
      tx_d      = d_req && (!if_req || starve_m < STARVE_LIMIT);
      tx_we     = tx_d ? d_we : 4'b0000;
      tx_addr   = tx_d ? d_addr : if_addr;
      tx_wdata  = tx_d ? d_wdata : 32'h0;
      starve_m  = (tx_d && if_req) ? starve_m + 1 : 0;
      tx_active = 1'b1;
      tx_start  = cyc;
    end

    chk1("m_req", m_req, tx_active);
    if (tx_active) begin
      chk32("m_we", {28'h0, m_we}, {28'h0, tx_we});
      chk32("m_addr", m_addr, tx_addr);
      chk32("m_wdata", m_wdata, tx_wdata);
    end
    chk1("if_rdy", if_rdy, exp_ifr);
    chk1("d_rdy", d_rdy, exp_dr);
    chk32("if_rdata", if_rdata, exp_if_rdata);
    chk32("d_rdata", d_rdata, exp_d_rdata);
    chk1("timeout_err", timeout_err, exp_err);
    chk1("stall_if", stall_if, if_req & ~exp_ifr);
    chk1("stall_mem", stall_mem, d_req & ~exp_dr);
  endtask

  function automatic int rand_lat();
    int r;
    r = $urandom_range(0, 39);
    if (r == 0) return 64;
    if (r == 1) return 70;
    return $urandom_range(1, 4);
  endfunction

  // Memory side: ack after the chosen latency, apply stores, return load data
  task automatic mem_drive();
    int idx;
    idx = int'(m_addr[7:2]);
    if (!rst_n) begin
      m_ack    = 1'b0;
      mem_wait = 0;
    end else if (m_req) begin
      if (mem_wait == 0) mem_lat = (lat_cfg != 0) ? lat_cfg : rand_lat();
      mem_wait++;
      if (mem_wait >= mem_lat) begin
        m_ack   = 1'b1;
        m_rdata = mem[idx];
        for (int b = 0; b < 4; b++)
          if (m_we[b]) mem[idx][8*b +: 8] = m_wdata[8*b +: 8];
      end else begin
        m_ack   = 1'b0;
        m_rdata = $urandom;
      end
    end else begin
      mem_wait = 0;
      m_ack    = spurious_en && ($urandom_range(0, 7) == 0);
      m_rdata  = $urandom;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    model_step();
    mem_drive();
  endtask

  task automatic wait_rdy(input bit want_d, input int bound);
    int n;
    n = 0;
    tick();
    while (!(want_d ? d_rdy : if_rdy) && n < bound) begin
      tick();
      n++;
    end
    chk1(want_d ? "d_rdy_seen" : "if_rdy_seen", want_d ? d_rdy : if_rdy, 1'b1);
  endtask

  // Random requesters: hold until ready, sometimes give up before a grant
  task automatic req_drive();
    if (if_req && if_rdy) if_req = 1'b0;
    else if (if_req && $urandom_range(0, 15) == 0) if_req = 1'b0;
    if (!if_req && !(tx_active && !tx_d) && $urandom_range(0, 1) == 1) begin
      if_req  = 1'b1;
      if_addr = 32'($urandom_range(0, 63)) << 2;
    end
    if (d_req && d_rdy) d_req = 1'b0;
    else if (d_req && $urandom_range(0, 15) == 0) d_req = 1'b0;
    if (!d_req && !(tx_active && tx_d) && $urandom_range(0, 1) == 1) begin
      d_req   = 1'b1;
      d_addr  = 32'($urandom_range(0, 63)) << 2;
      d_wdata = $urandom;
      d_we    = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
    end
  endtask

  initial begin
    int c0;
    int n;
    int ng;
    int cnt;
    int g0;
    int g1;
    logic prev;
    logic [31:0] pat;

    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = '0;
    d_addr = '0; d_wdata = '0; m_rdata = '0; m_ack = 1'b0;
    lat_cfg = 1; spurious_en = 1'b0; mem_wait = 0; mem_lat = 1;
    tx_active = 1'b0; idle_at = 0; starve_m = 0; g0 = 0; g1 = 0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0]  = 32'h0000_0013;
    mem[1]  = 32'hCAFE_0001;
    mem[18] = 32'h600D_F00D;

    tick(); tick();
    chk1("rst_m_req", m_req, 1'b0);
    chk32("rst_m_addr", m_addr, 32'h0);
    chk32("rst_m_wdata", m_wdata, 32'h0);
    chk32("rst_m_we", {28'h0, m_we}, 32'h0);
    chk32("rst_if_rdata", if_rdata, 32'h0);
    chk1("rst_timeout_err", timeout_err, 1'b0);
    rst_n = 1'b1;
    tick(); tick();

    // single fetch, memory acks one cycle after m_req
    lat_cfg = 2;
    if_req = 1'b1; if_addr = 32'h100;
    #1 chk1("fetch_stall_c0", stall_if, 1'b1);
    c0 = cyc;
    tick();
    chk1("fetch_m_req_c1", m_req, 1'b1);
    chk32("fetch_m_addr", m_addr, 32'h100);
    chk32("fetch_m_we", {28'h0, m_we}, 32'h0);
    tick();
    chk1("fetch_stall_c2", stall_if, 1'b1);
    tick();
    chk32("fetch_rdy_cycle", 32'(cyc - c0), 32'd3);
    chk1("fetch_if_rdy_c3", if_rdy, 1'b1);
    chk32("fetch_if_rdata", if_rdata, 32'h13);
    if_req = 1'b0;
    tick();
    chk1("fetch_if_rdy_c4", if_rdy, 1'b0);

    // partial store, then load it back
    lat_cfg = 1;
    d_req = 1'b1; d_we = 4'b0011; d_addr = 32'h2000; d_wdata = 32'hABCD_1234;
    tick();
    chk32("store_m_we", {28'h0, m_we}, 32'h3);
    chk32("store_m_wdata", m_wdata, 32'hABCD_1234);
    tick();
    chk1("store_d_rdy", d_rdy, 1'b1);
    chk32("store_d_rdata_held", d_rdata, 32'h0);
    d_req = 1'b0;
    tick();
    chk1("store_d_rdy_once", d_rdy, 1'b0);
    d_req = 1'b1; d_we = 4'b0000;
    wait_rdy(1'b1, 20);
    chk32("load_after_store", d_rdata, 32'h0000_1234);
    d_req = 1'b0;
    tick();

    // both requesters held: data wins four times, then fetch
    if_req = 1'b1; if_addr = 32'h80;
    d_req = 1'b1; d_we = 4'b0000; d_addr = 32'h44;
    prev = m_req; pat = '0; ng = 0; n = 0;
    while (ng < 10 && n < 200) begin
      tick();
      n++;
      if (m_req && !prev) begin
        pat = {pat[30:0], (m_addr == 32'h44)};
        if (ng == 0) g0 = cyc;
        if (ng == 1) g1 = cyc;
        ng++;
      end
      prev = m_req;
    end
    chk32("grant_order", pat, 32'b11_1101_1110);
    chk32("grant_spacing", 32'(g1 - g0), 32'd3);
    if_req = 1'b0; d_req = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // ack lands in the cycle the wait timer expires
    lat_cfg = 64;
    d_req = 1'b1; d_we = 4'b0000; d_addr = 32'h48;
    wait_rdy(1'b1, 100);
    chk32("collide_d_rdata", d_rdata, 32'h600D_F00D);
    chk1("collide_no_err", timeout_err, 1'b0);
    d_req = 1'b0;
    tick();

    // memory never answers
    lat_cfg = 100000;
    d_req = 1'b1; d_addr = 32'h4C;
    cnt = 0; n = 0;
    while (!d_rdy && n < 200) begin
      tick();
      n++;
      if (m_req) cnt++;
    end
    chk32("timeout_busy_cycles", 32'(cnt), 32'd64);
    chk32("timeout_d_rdata", d_rdata, 32'hDEAD_BEEF);
    chk1("timeout_err_set", timeout_err, 1'b1);
    d_req = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk1("timeout_err_sticky", timeout_err, 1'b1);

    // reset while a fetch is in flight
    if_req = 1'b1; if_addr = 32'h104;
    for (int i = 0; i < 4; i++) tick();
    chk1("rstmid_busy", m_req, 1'b1);
    rst_n = 1'b0;
    #1 chk1("rstmid_m_req_async", m_req, 1'b0);
    if_req = 1'b0;
    tick(); tick();
    chk1("rstmid_err_clear", timeout_err, 1'b0);
    rst_n = 1'b1;
    tick();
    lat_cfg = 1;
    if_req = 1'b1;
    wait_rdy(1'b0, 20);
    chk32("rstmid_refetch", if_rdata, 32'hCAFE_0001);
    if_req = 1'b0;
    tick();

    // randomized traffic
    lat_cfg = 0;
    spurious_en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      tick();
      req_drive();
    end
    if_req = 1'b0; d_req = 1'b0;
    spurious_en = 1'b0;
    for (int i = 0; i < 80; i++) tick();

    rst_n = 1'b0;
    tick();
    chk1("final_reset_err", timeout_err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
